lag_feeder8_64: RTL and testbench

//  Upstream stage of the 8-bit/64-lag RAM-based correlator MAC bank. Stores the last 64 input

---
 rtl/corr_pkg.sv | 21 ++
 rtl/hist_ram_dp.sv | 24 ++
 rtl/lag_feeder8_64.sv | 109 ++++++++++
 tb/tb_lag_feeder8_64.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared correlator constants and the lag feeder's FSM encoding.
// The MAC bank sizes its address sweep from the same LAGS/AW.
package corr_pkg;
  localparam int DW   = 8;
  localparam int LAGS = 64;
  localparam int AW   = 6;
  localparam int CW   = 16;

  localparam logic [AW-1:0] LAST_K   = AW'(LAGS - 1);
  localparam logic [AW:0]   FILL_MAX = (AW + 1)'(LAGS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hist_ram_dp.sv
// Sample history store: one write port, one read port with registered data, no reset.
// Read data appears the cycle after i_re; the output register holds when i_re is low.
module hist_ram_dp #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/lag_feeder8_64.sv
// Feeds the lag MAC bank: one sin pulse per accepted sample, then x(n-k) for k = 0..63.
// 66 cycles per sample; samples arriving mid-sweep are dropped and counted.
module lag_feeder8_64
  import corr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  input  logic          hist_clr,
  output logic          busy,
  output logic          mac_sin,
  output logic [DW-1:0] mac_A,
  output logic [DW-1:0] mac_B,
  output logic          overrun,
  output logic [CW-1:0] overrun_cnt
);
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_wp, r_k;
  logic [AW:0]   r_fill;
  logic          r_busy, r_mac_sin, r_b_vld, r_overrun;
  logic [DW-1:0] r_mac_a;
  logic [CW-1:0] r_ovr_cnt;

  logic          w_accept, w_clr, w_drop, w_last, w_rd_en, w_b_vld_nxt;
  logic [AW-1:0] w_lag, w_rd_addr;
  logic [DW-1:0] w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ARM;
      ST_ARM:   w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_k == LAST_K) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Read for lag k+1 is issued while lag k is on mac_B; the newest sample sits at wp-1.
  always_comb begin
    w_clr       = (r_state == ST_IDLE) && hist_clr;
    w_accept    = (r_state == ST_IDLE) && sample_valid && !hist_clr;
    w_drop      = (r_state != ST_IDLE) && sample_valid;
    w_last      = (r_state == ST_SWEEP) && (r_k == LAST_K);
    w_lag       = (r_state == ST_SWEEP) ? r_k + 1'b1 : '0;
    w_rd_addr   = r_wp - 1'b1 - w_lag;
    w_rd_en     = (r_state == ST_ARM) || ((r_state == ST_SWEEP) && !w_last);
    w_b_vld_nxt = w_rd_en && ({1'b0, w_lag} < r_fill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_fill    <= '0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_mac_sin <= 1'b0;
      r_b_vld   <= 1'b0;
      r_mac_a   <= '0;
      r_overrun <= 1'b0;
      r_ovr_cnt <= '0;
    end else begin
      r_mac_sin <= w_accept;
      r_b_vld   <= w_b_vld_nxt;
      if (w_accept) begin
        r_mac_a <= sample_in;
        r_wp    <= r_wp + 1'b1;
        r_busy  <= 1'b1;
        if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
      end else if (w_last) begin
        r_busy <= 1'b0;
      end
      if (r_state == ST_ARM)        r_k <= '0;
      else if (r_state == ST_SWEEP) r_k <= r_k + 1'b1;
      if (w_clr) begin
        r_wp      <= '0;
        r_fill    <= '0;
        r_overrun <= 1'b0;
        r_ovr_cnt <= '0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
        r_ovr_cnt <= sat_inc(r_ovr_cnt);
      end
    end
  end

  hist_ram_dp #(.DW(DW), .AW(AW)) u_hist (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wp),
    .i_wdata (sample_in),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  // RAM data is not reset; the registered valid bit zeroes masked lags and forces 0 on reset.
  assign mac_B       = r_b_vld ? w_rdata : '0;
  assign busy        = r_busy;
  assign mac_sin     = r_mac_sin;
  assign mac_A       = r_mac_a;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_ovr_cnt;
endmodule

// File: tb/tb_lag_feeder8_64.sv
// Bench for lag_feeder8_64: a reference history queue predicts each sweep's mac_B stream,
// which is queued at accept time and popped as the sweep plays out.
module tb_lag_feeder8_64;
  import corr_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          hist_clr = 1'b0;
  logic          busy, mac_sin, overrun;
  logic [DW-1:0] mac_A, mac_B;
  logic [CW-1:0] overrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_hist[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ovr = 1'b0;
  int            m_ovr_cnt = 0;

  lag_feeder8_64 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .hist_clr     (hist_clr),
    .busy         (busy),
    .mac_sin      (mac_sin),
    .mac_A        (mac_A),
    .mac_B        (mac_B),
    .overrun      (overrun),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_lag(input int k);
    if (k < m_hist.size()) return m_hist[m_hist.size() - 1 - k];
    return '0;
  endfunction

  task automatic model_clear();
    m_hist.delete();
    m_ovr     = 1'b0;
    m_ovr_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_clear();
  endtask

  // One full sweep; drop_c / clr_c inject sample_valid / hist_clr at cycle T2+c (-1 = none).
  task automatic do_accept(input logic [DW-1:0] v, input int drop_c, input int clr_c);
    logic [DW-1:0] e;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mac_sin} !== 2'b00) begin
      n_errors++;
      $display("FAIL idle_before_accept: busy,mac_sin=%b required 00", {busy, mac_sin});
    end
    sample_valid = 1'b1;
    sample_in    = v;
    m_hist.push_back(v);
    if (m_hist.size() > LAGS) void'(m_hist.pop_front());
    for (int k = 0; k < LAGS; k++) exp_q.push_back(model_lag(k));

    @(posedge clk); #1;
    sample_valid = 1'b0;
    n_checks++;
    if (mac_sin !== 1'b1) begin
      n_errors++; $display("FAIL sin_at_T1: mac_sin=%b required 1", mac_sin);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL busy_at_T1: busy=%b required 1", busy);
    end

    for (int c = 0; c < LAGS; c++) begin
      @(posedge clk); #1;
      sample_valid = (c == drop_c);
      hist_clr     = (c == clr_c);
      if (c == drop_c) begin
        sample_in = 8'hEE;
        m_ovr     = 1'b1;
        if (m_ovr_cnt < 65535) m_ovr_cnt++;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (mac_B !== e) begin
        n_errors++; $display("FAIL lag k=%0d: mac_B=%0d required %0d", c, mac_B, e);
      end
      n_checks++;
      if ({busy, mac_sin} !== 2'b10) begin
        n_errors++; $display("FAIL sweep_flags k=%0d: busy,mac_sin=%b required 10", c, {busy, mac_sin});
      end
      n_checks++;
      if (mac_A !== v) begin
        n_errors++; $display("FAIL mac_A k=%0d: mac_A=%0d required %0d", c, mac_A, v);
      end
    end

    @(posedge clk); #1;
    sample_valid = 1'b0;
    hist_clr     = 1'b0;
    n_checks++;
    if ({busy, mac_B} !== {1'b0, 8'h00}) begin
      n_errors++; $display("FAIL sweep_end: busy=%b mac_B=%0d required 0,0", busy, mac_B);
    end
    n_checks++;
    if (overrun !== m_ovr || overrun_cnt !== CW'(m_ovr_cnt)) begin
      n_errors++;
      $display("FAIL overrun_state: overrun=%b cnt=%0d required %b,%0d", overrun, overrun_cnt, m_ovr, m_ovr_cnt);
    end
  endtask

  task automatic test_reset();
    #23;
    n_checks++;
    if ({busy, mac_sin, overrun} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: busy,mac_sin,overrun=%b required 000", {busy, mac_sin, overrun});
    end
    n_checks++;
    if (mac_A !== '0 || mac_B !== '0) begin
      n_errors++; $display("FAIL reset_data: mac_A=%0d mac_B=%0d required 0,0", mac_A, mac_B);
    end
    n_checks++;
    if (overrun_cnt !== '0) begin
      n_errors++; $display("FAIL reset_cnt: overrun_cnt=%0d required 0", overrun_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_single();
    do_accept(8'd5, -1, -1);
  endtask

  task automatic test_three();
    do_reset();
    for (int i = 1; i <= 3; i++) do_accept(8'(i), -1, -1);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 70; i++) do_accept(8'(i), -1, -1);
  endtask

  task automatic test_overrun();
    do_reset();
    do_accept(8'd11, -1, -1);
    do_accept(8'd22, -1, -1);
    do_accept(8'd33, 8, -1);
    do_accept(8'd44, -1, 20);
    do_accept(8'd55, -1, -1);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) do_accept(8'(100 + i), -1, -1);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    hist_clr     = 1'b1;
    sample_in    = 8'd77;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    hist_clr     = 1'b0;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({busy, mac_sin} !== 2'b00) begin
        n_errors++; $display("FAIL clr_no_sweep c=%0d: busy,mac_sin=%b required 00", c, {busy, mac_sin});
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (overrun !== 1'b0 || overrun_cnt !== '0) begin
      n_errors++; $display("FAIL clr_overrun: overrun=%b cnt=%0d required 0,0", overrun, overrun_cnt);
    end
    do_accept(8'd9, -1, -1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_in    = 8'd7;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, mac_sin} !== 2'b00) begin
      n_errors++; $display("FAIL midreset_flags: busy,mac_sin=%b required 00", {busy, mac_sin});
    end
    n_checks++;
    if (mac_A !== '0 || mac_B !== '0) begin
      n_errors++; $display("FAIL midreset_data: mac_A=%0d mac_B=%0d required 0,0", mac_A, mac_B);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({busy, mac_sin} !== 2'b00) begin
        n_errors++; $display("FAIL midreset_quiet c=%0d: busy,mac_sin=%b required 00", c, {busy, mac_sin});
      end
    end
    do_accept(8'd5, -1, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_wrap();
    test_overrun();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
